// File: rtl/maze_pkg.sv
// Shared types for the maze path solver: FSM states, coordinate struct and
// neighbour offset tables for the 4- and 8-neighbour search modes.
package maze_pkg;

  typedef enum logic [2:0] {
    LOAD,
    INIT,
    SEARCH,
    EMIT,
    FAIL
  } state_t;

  // Widest coordinate the solver supports (N = 16).
  localparam int MAX_W = 4;

  typedef struct packed {
    logic [MAX_W-1:0] row;
    logic [MAX_W-1:0] col;
  } coord_t;

  // Orthogonal priority: down, right, up, left.
  localparam int NDIR4 = 4;
  localparam int DIR4_DR [NDIR4] = '{1, 0, -1, 0};
  localparam int DIR4_DC [NDIR4] = '{0, 1, 0, -1};

  // Diagonal priority: DR, D, R, DL, UR, U, L, UL.
  localparam int NDIR8 = 8;
  localparam int DIR8_DR [NDIR8] = '{1, 1, 0, 1, -1, -1, 0, -1};
  localparam int DIR8_DC [NDIR8] = '{1, 0, 1, -1, 1, 0, -1, -1};

endpackage

// File: rtl/maze_nbr_sel.sv
// Combinational neighbour selector: first in-bounds, open, unvisited cell
// around the current coordinate. Define MAZE_DIAG_EN for 8-neighbour moves.
module maze_nbr_sel
  import maze_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  coord_t             cur,
  input  logic [N*N-1:0]     open_map,
  input  logic [N*N-1:0]     visited,
  output logic               found,
  output logic [2*W-1:0]     nxt
);

`ifdef MAZE_DIAG_EN
  localparam int NDIR = NDIR8;
  localparam int DR [NDIR] = DIR8_DR;
  localparam int DC [NDIR] = DIR8_DC;
`else
  localparam int NDIR = NDIR4;
  localparam int DR [NDIR] = DIR4_DR;
  localparam int DC [NDIR] = DIR4_DC;
`endif

  // Cell index is {row, col}, which equals row*N+col because N is a power of two.
  always_comb begin
    int r;
    int c;
    logic [2*W-1:0] idx;
    found = 1'b0;
    nxt   = '0;
    r     = 0;
    c     = 0;
    idx   = '0;
    for (int d = 0; d < NDIR; d++) begin
      r   = int'(cur.row) + DR[d];
      c   = int'(cur.col) + DC[d];
      idx = {W'(r), W'(c)};
      if (!found && r >= 0 && r < N && c >= 0 && c < N &&
          open_map[idx] && !visited[idx]) begin
        found = 1'b1;
        nxt   = idx;
      end
    end
  end

endmodule

// File: rtl/maze_path_solver.sv
// N x N rat-in-maze solver: row-wise load, stack-based DFS, handshaked path
// output with explicit no-path beat. Optional MAZE_DIAG_EN enables diagonals.
module maze_path_solver
  import maze_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] maze,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_row,
  output logic [W-1:0] out_col,
  output logic         out_last,
  output logic         out_fail
);

  localparam int CW = 2 * W;

  state_t          state_q, state_d;
  logic [W-1:0]    row_cnt;
  logic [N*N-1:0]  open_map;
  logic [N*N-1:0]  visited;
  logic [CW-1:0]   stack [N*N];
  logic [CW-1:0]   tos;
  logic [CW-1:0]   rd;
  logic [CW-1:0]   tos_cell;
  logic [CW-1:0]   nxt_cell;
  coord_t          top_c;
  logic            nbr_found;
  logic            at_goal;

  logic load_row, init_go, push, pop;
  logic emit_first, emit_adv, fail_set, out_clear;

  assign tos_cell  = stack[tos];
  assign top_c.row = MAX_W'(tos_cell[CW-1:W]);
  assign top_c.col = MAX_W'(tos_cell[W-1:0]);
  assign at_goal   = (tos_cell == '1);

  maze_nbr_sel #(.N(N), .W(W)) u_nbr_sel (
    .cur      (top_c),
    .open_map (open_map),
    .visited  (visited),
    .found    (nbr_found),
    .nxt      (nxt_cell)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_row   = 1'b0;
    init_go    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    emit_first = 1'b0;
    emit_adv   = 1'b0;
    fail_set   = 1'b0;
    out_clear  = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          load_row = 1'b1;
          if (row_cnt == W'(N - 1)) state_d = INIT;
        end
      end
      INIT: begin
        if (!open_map[0] || !open_map[N*N-1]) begin
          fail_set = 1'b1;
          state_d  = FAIL;
        end else begin
          init_go = 1'b1;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (at_goal) begin
          emit_first = 1'b1;
          state_d    = EMIT;
        end else if (nbr_found) begin
          push = 1'b1;
        end else if (tos == '0) begin
          // Popping the origin leaves the stack empty: no path exists.
          fail_set = 1'b1;
          state_d  = FAIL;
        end else begin
          pop = 1'b1;
        end
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            out_clear = 1'b1;
            state_d   = LOAD;
          end else begin
            emit_adv = 1'b1;
          end
        end
      end
      FAIL: begin
        if (out_ready) begin
          out_clear = 1'b1;
          state_d   = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: maze, visited map and stack are plain storage with no reset; every
  // entry read is written first (rows in LOAD, visited in INIT, stack on push).
  always_ff @(posedge clk) begin
    if (load_row) begin
      for (int c = 0; c < N; c++) begin
        open_map[{row_cnt, W'(c)}] <= maze[W'(N - 1 - c)];
      end
    end
    if (init_go) begin
      visited  <= (N*N)'(1);
      stack[0] <= '0;
    end
    if (push) begin
      stack[tos + 1'b1]  <= nxt_cell;
      visited[nxt_cell]  <= 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt   <= '0;
      tos       <= '0;
      rd        <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      out_fail  <= 1'b0;
    end else begin
      if (load_row) row_cnt <= row_cnt + 1'b1;
      if (init_go)  tos <= '0;
      if (push)     tos <= tos + 1'b1;
      if (pop)      tos <= tos - 1'b1;
      if (emit_first) begin
        out_valid <= 1'b1;
        out_row   <= stack[0][CW-1:W];
        out_col   <= stack[0][W-1:0];
        out_last  <= (tos == '0);
        out_fail  <= 1'b0;
        rd        <= CW'(1);
      end
      if (emit_adv) begin
        out_row  <= stack[rd][CW-1:W];
        out_col  <= stack[rd][W-1:0];
        out_last <= (rd == tos);
        rd       <= rd + 1'b1;
      end
      if (fail_set) begin
        out_valid <= 1'b1;
        out_row   <= '0;
        out_col   <= '0;
        out_last  <= 1'b1;
        out_fail  <= 1'b1;
      end
      if (out_clear) begin
        out_valid <= 1'b0;
        out_row   <= '0;
        out_col   <= '0;
        out_last  <= 1'b0;
        out_fail  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maze_path_solver.sv
// Self-checking bench for maze_path_solver (N=8 and N=4 instances); path
// expectations come from directed vectors and a queue-based DFS model.
module tb_maze_path_solver;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic [15:0] mbus;
  logic        rdy;
  logic        sel4;

  logic       ov8, l8, f8;
  logic [2:0] r8, c8;
  logic       ov4, l4, f4;
  logic [1:0] r4, c4;

  logic        ov, olast, ofail;
  logic [31:0] orow, ocol;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] row;
    logic [31:0] col;
    logic        last;
    logic        fail;
  } beat_t;

  beat_t got[$];
  int    exp_path[$];
  bit    exp_fail;
  int    rows[16];

`ifdef MAZE_DIAG_EN
  localparam int ND = 8;
  localparam int DR [ND] = '{1, 1, 0, 1, -1, -1, 0, -1};
  localparam int DC [ND] = '{1, 0, 1, -1, 1, 0, -1, -1};
`else
  localparam int ND = 4;
  localparam int DR [ND] = '{1, 0, -1, 0};
  localparam int DC [ND] = '{0, 1, 0, -1};
`endif

  always #5 clk = ~clk;

  maze_path_solver #(.N(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv && !sel4),
    .maze      (mbus[7:0]),
    .out_ready (rdy && !sel4),
    .out_valid (ov8),
    .out_row   (r8),
    .out_col   (c8),
    .out_last  (l8),
    .out_fail  (f8)
  );

  maze_path_solver #(.N(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv && sel4),
    .maze      (mbus[3:0]),
    .out_ready (rdy && sel4),
    .out_valid (ov4),
    .out_row   (r4),
    .out_col   (c4),
    .out_last  (l4),
    .out_fail  (f4)
  );

  assign ov    = sel4 ? ov4 : ov8;
  assign olast = sel4 ? l4 : l8;
  assign ofail = sel4 ? f4 : f8;
  assign orow  = sel4 ? 32'(r4) : 32'(r8);
  assign ocol  = sel4 ? 32'(c4) : 32'(c8);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference DFS over explicit grid arrays; the path is the final stack.
  function automatic void run_model(input int n, input int rw[16],
                                    output int path[$], output bit fl);
    bit open_c[16][16];
    bit vis[16][16];
    int stk[$];
    int t, tr, tc, nr, nc;
    bit moved;
    path = {};
    fl   = 1'b0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        open_c[r][c] = ((rw[r] >> (n - 1 - c)) & 1) != 0;
    if (!open_c[0][0] || !open_c[n-1][n-1]) begin
      fl = 1'b1;
      return;
    end
    stk.push_back(0);
    vis[0][0] = 1'b1;
    while (stk.size() > 0) begin
      t  = stk[$];
      tr = t / 16;
      tc = t % 16;
      if (tr == n - 1 && tc == n - 1) begin
        path = stk;
        return;
      end
      moved = 1'b0;
      for (int d = 0; d < ND; d++) begin
        nr = tr + DR[d];
        nc = tc + DC[d];
        if (!moved && nr >= 0 && nr < n && nc >= 0 && nc < n) begin
          if (open_c[nr][nc] && !vis[nr][nc]) begin
            stk.push_back(nr * 16 + nc);
            vis[nr][nc] = 1'b1;
            moved = 1'b1;
          end
        end
      end
      if (!moved) void'(stk.pop_back());
    end
    fl = 1'b1;
  endfunction

  task automatic load_maze(input int n, input bit gaps);
    sel4 = (n == 4);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        iv = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      iv   = 1'b1;
      mbus = 16'(rows[k]);
      @(posedge clk); #1;
    end
    iv = 1'b0;
  endtask

  // mode: 0 ready held high, 1 ready toggling, 2 ready random.
  task automatic collect(input int n, input int mode, input bit junk);
    int          cyc   = 0;
    int          first = -1;
    bit          done  = 1'b0;
    bit          pv    = 1'b0;
    bit          pr    = 1'b0;
    logic [31:0] prow  = '0;
    logic [31:0] pcol  = '0;
    logic        pl    = 1'b0;
    logic        pf    = 1'b0;
    beat_t       b;
    got = {};
    while (!done && cyc < 6 * n * n + 50) begin
      if (pv && !pr) begin
        check("stall_valid", 32'(ov), 1);
        check("stall_row", orow, prow);
        check("stall_col", ocol, pcol);
        check("stall_last", 32'(olast), 32'(pl));
        check("stall_fail", 32'(ofail), 32'(pf));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ~rdy;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (junk) begin
        iv   = 1'($urandom_range(0, 1));
        mbus = 16'($urandom);
      end
      if (ov === 1'b1 && first < 0) first = cyc;
      if (ov === 1'b1 && rdy) begin
        b.row  = orow;
        b.col  = ocol;
        b.last = olast;
        b.fail = ofail;
        got.push_back(b);
        if (olast === 1'b1) done = 1'b1;
      end
      pv   = (ov === 1'b1);
      pr   = rdy;
      prow = orow;
      pcol = ocol;
      pl   = olast;
      pf   = ofail;
      @(posedge clk); #1;
      cyc++;
    end
    iv  = 1'b0;
    rdy = 1'b0;
    check("emit_done_in_budget", 32'(done), 1);
    if (mode == 0 && done) check("throughput_cycles", 32'(cyc - first), 32'(got.size()));
  endtask

  task automatic compare(input string tag, input int path[$], input bit fl);
    if (fl) begin
      check({tag, "_nbeats"}, 32'(got.size()), 1);
      if (got.size() > 0) begin
        check({tag, "_fail"}, 32'(got[0].fail), 1);
        check({tag, "_last"}, 32'(got[0].last), 1);
        check({tag, "_row"}, got[0].row, 0);
        check({tag, "_col"}, got[0].col, 0);
      end
    end else begin
      check({tag, "_nbeats"}, 32'(got.size()), 32'(path.size()));
      for (int i = 0; i < got.size() && i < path.size(); i++) begin
        check({tag, "_coord"}, got[i].row * 16 + got[i].col, 32'(path[i]));
        check({tag, "_last"}, 32'(got[i].last), 32'(i == path.size() - 1));
        check({tag, "_fail"}, 32'(got[i].fail), 0);
      end
    end
  endtask

  task automatic run_case(input string tag, input int n, input int mode,
                          input bit gaps, input bit junk);
    load_maze(n, gaps);
    collect(n, mode, junk);
    compare(tag, exp_path, exp_fail);
  endtask

  task automatic set_maze1();
    rows = '{default: 0};
    rows[0] = 'h80; rows[1] = 'hF0; rows[2] = 'h5F; rows[3] = 'h5F;
    rows[4] = 'h4F; rows[5] = 'h77; rows[6] = 'h43; rows[7] = 'h73;
  endtask

  task automatic expect_maze1();
`ifdef MAZE_DIAG_EN
    run_model(8, rows, exp_path, exp_fail);
`else
    exp_path = {0, 16, 17, 18, 19, 35, 51, 52, 68, 69, 85, 86, 102, 118, 119};
    exp_fail = 1'b0;
`endif
  endtask

  task automatic random_maze(input int n);
    rows = '{default: 0};
    for (int k = 0; k < n; k++)
      for (int c = 0; c < n; c++)
        if ($urandom_range(0, 99) < 68) rows[k] |= 1 << (n - 1 - c);
    if ($urandom_range(0, 7) != 0) begin
      rows[0]   |= 1 << (n - 1);
      rows[n-1] |= 1;
    end
  endtask

  initial begin
    rst  = 1'b1;
    iv   = 1'b0;
    rdy  = 1'b0;
    mbus = '0;
    sel4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_n8", 32'({ov8, l8, f8, r8, c8}), 0);
    check("reset_outputs_n4", 32'({ov4, l4, f4, r4, c4}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    set_maze1();
    expect_maze1();
    run_case("maze1_ready_high", 8, 0, 1'b0, 1'b0);

    set_maze1();
    expect_maze1();
    run_case("maze1_ready_toggle", 8, 1, 1'b0, 1'b0);

    set_maze1();
    rows[7] = 'hFE;
    exp_path = {};
    exp_fail = 1'b1;
    run_case("goal_walled", 8, 0, 1'b0, 1'b0);

    rows = '{default: 0};
    rows[0] = 'h8; rows[1] = 'h8; rows[2] = 'h8; rows[3] = 'hF;
`ifdef MAZE_DIAG_EN
    run_model(4, rows, exp_path, exp_fail);
`else
    exp_path = {0, 16, 32, 48, 49, 50, 51};
    exp_fail = 1'b0;
`endif
    run_case("n4_l_shape", 4, 0, 1'b0, 1'b0);

    rows = '{default: 0};
    rows[0] = 'h8; rows[1] = 'h4; rows[2] = 'h2; rows[3] = 'h1;
`ifdef MAZE_DIAG_EN
    exp_path = {0, 17, 34, 51};
    exp_fail = 1'b0;
`else
    exp_path = {};
    exp_fail = 1'b1;
`endif
    run_case("n4_diagonal", 4, 2, 1'b0, 1'b0);

    // Reset in the middle of SEARCH, then reload the same maze.
    set_maze1();
    load_maze(8, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_mid_search_outputs", 32'({ov8, l8, f8, r8, c8}), 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    expect_maze1();
    run_case("maze1_after_reset", 8, 0, 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      random_maze(8);
      run_model(8, rows, exp_path, exp_fail);
      run_case("random_n8", 8, 2, 1'b1, 1'b1);
    end
    for (int t = 0; t < 6; t++) begin
      random_maze(4);
      run_model(4, rows, exp_path, exp_fail);
      run_case("random_n4", 4, 2, 1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maze_path_solver.md
# maze_path_solver

Parametrised successor to the fixed 8x8 rat-in-maze solver. Loads an N x N maze one row per accepted `in_valid` beat, finds a path from (0,0) to (N-1,N-1) with a stack-based depth-first search, and streams the path out one coordinate per handshake. Adds configurable size, an `out_ready` back-pressure handshake, explicit no-path reporting, and an optional diagonal-move mode. Sits between the maze loader and the path consumer in the exercise datapath.

## Interface
- `N`, default 8: maze side; power of two, 4..16.
- `W`, default `$clog2(N)`: coordinate width (derived; do not override).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  maze row present on `maze`.
- `maze`  in  N  one maze row; bit N-1 = column 0; 1 = open, 0 = wall.
- `out_ready`  in  1  consumer accepts current coordinate.
- `out_valid`  out  1  `out_row`/`out_col`/`out_last`/`out_fail` valid.
- `out_row`  out  W  path row.
- `out_col`  out  W  path column.
- `out_last`  out  1  current beat is the goal coordinate, or the fail beat.
- `out_fail`  out  1  no path exists; single beat, coordinates 0.

## Operation
- States: LOAD, INIT, SEARCH, EMIT, FAIL.
- LOAD: row k stored on the k-th cycle with `in_valid`=1; gaps allowed. After row N-1 go to INIT.
- INIT (1 cycle): clear visited map. If (0,0) or (N-1,N-1) is a wall go to FAIL. Otherwise push (0,0), mark it visited, go to SEARCH.
- SEARCH: one action per cycle on top-of-stack T.
  - T = (N-1,N-1): go to EMIT, read pointer = 0.
  - Else pick the first in-bounds, open, unvisited neighbour in priority order down, right, up, left. Push it and mark it visited.
  - Else pop T. If the stack becomes empty, go to FAIL.
- Stack depth N*N, entries 2W bits. The visited map guarantees no overflow.
- SEARCH terminates within 2*N*N cycles.
- EMIT: present stack[rd]. Advance only when `out_valid && out_ready`. `out_last`=1 on the top entry. Accepting the last beat returns to LOAD.
- FAIL: `out_valid`=`out_fail`=`out_last`=1 until accepted, then return to LOAD.
- `in_valid` outside LOAD is ignored; the maze is not modified.
- Outputs hold stable while `out_valid && !out_ready`.
- Reset, including mid-search or mid-emit: state LOAD, row counter 0, stack empty, all outputs 0. Stored maze contents are don't-care.

## Timing
- Outputs are registered. `out_valid` first rises 2 cycles after the last row plus the SEARCH cycles (INIT + SEARCH + 1).
- Output throughput is 1 coordinate per cycle when `out_ready` is held high.
- A new maze is accepted the cycle after the last output beat is accepted.

## Configuration
- `MAZE_DIAG_EN` defined: 8-neighbour search. Priority order: down-right, down, right, down-left, up-right, up, left, up-left. A diagonal move needs only the target cell open (corner cutting allowed).
- `MAZE_DIAG_EN` undefined: 4-neighbour search exactly as in Operation.

## Structure
- Package `maze_pkg`: state enum, direction-offset constants per mode, coordinate struct {row, col}.
- Sub-module `maze_nbr_sel`: combinational priority selector. Takes T, the maze and the visited map; returns the found flag and the next coordinate. The `MAZE_DIAG_EN` switch lives inside it.

## Test plan
- Load rows 80,F0,5F,5F,4F,77,43,73 (hex, N=8), `out_ready`=1 -> 15 beats: (0,0)(1,0)(1,1)(1,2)(1,3)(2,3)(3,3)(3,4)(4,4)(4,5)(5,5)(5,6)(6,6)(7,6)(7,7). `out_last` on (7,7); `out_fail`=0.
- Same maze, `out_ready` toggling 1/0 each cycle -> identical sequence; no beat lost or duplicated; outputs stable while stalled.
- Row 7 = FE (goal walled) -> single beat with `out_fail`=1, `out_last`=1, row/col 0.
- N=4, rows 8,8,8,F -> (0,0)(1,0)(2,0)(3,0)(3,1)(3,2)(3,3).
- Assert `rst` during SEARCH, then reload the first maze -> `out_valid` stays 0 during reset; the subsequent path is the same 15 beats.
- `MAZE_DIAG_EN`, N=4, rows 8,4,2,1 -> (0,0)(1,1)(2,2)(3,3).
